// File: rtl/comp_minmax_track_pkg.sv
// Shared types for the running min/max tracker: FSM encoding and compare-flag layout.
// Pure declarations; no logic, no latency, no flow control.
package comp_minmax_track_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_TRACK = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    typedef struct packed {
        logic gt;
        logic eq;
        logic lt;
    } flags_t;

    localparam flags_t FLAGS_NONE = '{gt: 1'b0, eq: 1'b0, lt: 1'b0};
    localparam flags_t FLAGS_EQ   = '{gt: 1'b0, eq: 1'b1, lt: 1'b0};

endpackage

// File: rtl/comp_minmax_track_core.sv
// Magnitude compare of a against b, both operands sharing one signedness.
// Purely combinational, 0 cycles; no flow control.
module comp_core #(
    parameter int DATAWIDTH = 8,
    parameter int SIGNED    = 1
) (
    input  logic [DATAWIDTH-1:0] a,
    input  logic [DATAWIDTH-1:0] b,
    output logic                 gt,
    output logic                 eq,
    output logic                 lt
);

    // Flipping the sign bit maps two's-complement order onto unsigned order.
    localparam logic [DATAWIDTH-1:0] BIAS = {(SIGNED != 0), {(DATAWIDTH-1){1'b0}}};

    logic [DATAWIDTH-1:0] a_b;
    logic [DATAWIDTH-1:0] b_b;

    assign a_b = a ^ BIAS;
    assign b_b = b ^ BIAS;
    assign gt  = (a_b > b_b);
    assign eq  = (a == b);
    assign lt  = (a_b < b_b);

endmodule

// File: rtl/comp_minmax_track.sv
// Running max/min tracker with first-occurrence indices; results registered 1 cycle after accept.
// InReady drops in DONE or during Clr; stream ends on InLast or counter saturation, Clr restarts.
module comp_minmax_track
    import comp_minmax_track_pkg::*;
#(
    parameter int DATAWIDTH = 8,
    parameter int CNTWIDTH  = 8,
    parameter int SIGNED    = 1
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic                 Clr,
    input  logic                 InValid,
    input  logic [DATAWIDTH-1:0] InData,
    input  logic                 InLast,
    output logic                 InReady,
    output logic [DATAWIDTH-1:0] Max,
    output logic [DATAWIDTH-1:0] Min,
    output logic [CNTWIDTH-1:0]  MaxIdx,
    output logic [CNTWIDTH-1:0]  MinIdx,
    output logic [CNTWIDTH-1:0]  Count,
    output logic                 OutValid,
    output logic                 Gt,
    output logic                 Eq,
    output logic                 Lt
);

    localparam logic [CNTWIDTH-1:0] CNT_SAT = '1;

    state_t               state_q;
    state_t               state_d;
    logic                 accept;
    logic [CNTWIDTH-1:0]  count_inc;
    logic                 max_gt, max_eq, max_lt;
    logic                 min_gt, min_eq, min_lt;
    logic                 unused_min_flags;

    comp_core #(.DATAWIDTH(DATAWIDTH), .SIGNED(SIGNED)) u_cmp_max (
        .a  (InData),
        .b  (Max),
        .gt (max_gt),
        .eq (max_eq),
        .lt (max_lt)
    );

    comp_core #(.DATAWIDTH(DATAWIDTH), .SIGNED(SIGNED)) u_cmp_min (
        .a  (InData),
        .b  (Min),
        .gt (min_gt),
        .eq (min_eq),
        .lt (min_lt)
    );

    assign unused_min_flags = &{1'b0, min_gt, min_eq};

    assign InReady   = ~Clr & (state_q != ST_DONE);
    assign accept    = InValid & InReady;
    assign count_inc = Count + 1'b1;

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (Clr) begin
            state_d = ST_EMPTY;
        end else if (accept) begin
            case (state_q)
                ST_EMPTY: state_d = InLast ? ST_DONE : ST_TRACK;
                // Reaching all-ones ends the stream so Count never wraps.
                ST_TRACK: state_d = (InLast || (count_inc == CNT_SAT)) ? ST_DONE : ST_TRACK;
                default:  state_d = state_q;
            endcase
        end
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            Max          <= '0;
            Min          <= '0;
            MaxIdx       <= '0;
            MinIdx       <= '0;
            Count        <= '0;
            OutValid     <= 1'b0;
            {Gt, Eq, Lt} <= FLAGS_NONE;
        end else if (Clr) begin
            Max          <= '0;
            Min          <= '0;
            MaxIdx       <= '0;
            MinIdx       <= '0;
            Count        <= '0;
            OutValid     <= 1'b0;
            {Gt, Eq, Lt} <= FLAGS_NONE;
        end else begin
            OutValid <= (state_q == ST_DONE);
            if (accept) begin
                Count <= count_inc;
                if (state_q == ST_EMPTY) begin
                    Max          <= InData;
                    Min          <= InData;
                    MaxIdx       <= '0;
                    MinIdx       <= '0;
                    {Gt, Eq, Lt} <= FLAGS_EQ;
                end else begin
                    {Gt, Eq, Lt} <= {max_gt, max_eq, max_lt};
                    // Strict compares: ties keep the earlier index.
                    if (max_gt) begin
                        Max    <= InData;
                        MaxIdx <= Count;
                    end
                    if (min_lt) begin
                        Min    <= InData;
                        MinIdx <= Count;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_comp_minmax_track.sv
module tb_comp_minmax_track;

    logic       Clk = 1'b0;
    logic       Rst;
    logic       Clr;
    logic       InValid;
    logic [7:0] InData;
    logic       InLast;

    logic       s_rdy, s_ov, s_gt, s_eq, s_lt;
    logic [7:0] s_max, s_min, s_maxi, s_mini, s_cnt;
    logic       u_rdy, u_ov, u_gt, u_eq, u_lt;
    logic [7:0] u_max, u_min, u_maxi, u_mini, u_cnt;
    logic       c_rdy, c_ov, c_gt, c_eq, c_lt;
    logic [7:0] c_max, c_min;
    logic [1:0] c_maxi, c_mini, c_cnt;

    always #5 Clk = ~Clk;

    comp_minmax_track #(.DATAWIDTH(8), .CNTWIDTH(8), .SIGNED(1)) u_s (
        .Clk(Clk), .Rst(Rst), .Clr(Clr), .InValid(InValid), .InData(InData), .InLast(InLast),
        .InReady(s_rdy), .Max(s_max), .Min(s_min), .MaxIdx(s_maxi), .MinIdx(s_mini),
        .Count(s_cnt), .OutValid(s_ov), .Gt(s_gt), .Eq(s_eq), .Lt(s_lt));

    comp_minmax_track #(.DATAWIDTH(8), .CNTWIDTH(8), .SIGNED(0)) u_u (
        .Clk(Clk), .Rst(Rst), .Clr(Clr), .InValid(InValid), .InData(InData), .InLast(InLast),
        .InReady(u_rdy), .Max(u_max), .Min(u_min), .MaxIdx(u_maxi), .MinIdx(u_mini),
        .Count(u_cnt), .OutValid(u_ov), .Gt(u_gt), .Eq(u_eq), .Lt(u_lt));

    comp_minmax_track #(.DATAWIDTH(8), .CNTWIDTH(2), .SIGNED(1)) u_c (
        .Clk(Clk), .Rst(Rst), .Clr(Clr), .InValid(InValid), .InData(InData), .InLast(InLast),
        .InReady(c_rdy), .Max(c_max), .Min(c_min), .MaxIdx(c_maxi), .MinIdx(c_mini),
        .Count(c_cnt), .OutValid(c_ov), .Gt(c_gt), .Eq(c_eq), .Lt(c_lt));

    int nvec = 0;
    int nbad = 0;

    // Reference model: per instance, the list of accepted samples plus stream state.
    int         cap[3] = '{255, 255, 3};
    bit         sg[3]  = '{1'b1, 1'b0, 1'b1};
    logic [7:0] hist[3][256];
    int         n[3];
    bit         done[3];
    bit         ov[3];
    logic [2:0] fl[3];

    function automatic int val(input int k, input logic [7:0] d);
        return sg[k] ? int'($signed(d)) : int'({24'b0, d});
    endfunction

    function automatic void ext(input int k, input bit want_max, output logic [7:0] v, output int idx);
        v = 8'h00;
        idx = 0;
        for (int i = 0; i < n[k]; i++) begin
            if (i == 0 || (want_max ? (val(k, hist[k][i]) > val(k, v)) : (val(k, hist[k][i]) < val(k, v)))) begin
                v = hist[k][i];
                idx = i;
            end
        end
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            n[k] = 0; done[k] = 1'b0; ov[k] = 1'b0; fl[k] = 3'b000;
        end
    endtask

    task automatic model_step(input bit c, input bit v, input logic [7:0] d, input bit l);
        logic [7:0] m;
        int         mi;
        for (int k = 0; k < 3; k++) begin
            if (c) begin
                n[k] = 0; done[k] = 1'b0; ov[k] = 1'b0; fl[k] = 3'b000;
            end else begin
                ov[k] = done[k];
                if (v && !done[k]) begin
                    if (n[k] == 0) begin
                        fl[k] = 3'b010;
                    end else begin
                        ext(k, 1'b1, m, mi);
                        if (val(k, d) > val(k, m))       fl[k] = 3'b100;
                        else if (val(k, d) == val(k, m)) fl[k] = 3'b010;
                        else                             fl[k] = 3'b001;
                    end
                    hist[k][n[k]] = d;
                    n[k]++;
                    if (l || n[k] == cap[k]) done[k] = 1'b1;
                end
            end
        end
    endtask

    task automatic cmp(input string name, input int k, input logic [31:0] act, input logic [31:0] exp_v);
        nvec++;
        if (act !== exp_v) begin
            nbad++;
            $display("FAIL %s inst%0d: got %0h, expected %0h at %0t", name, k, act, exp_v, $time);
        end
    endtask

    task automatic check_inst(input int k, input logic [31:0] amax, input logic [31:0] amin,
                              input logic [31:0] amaxi, input logic [31:0] amini, input logic [31:0] acnt,
                              input logic [31:0] aov, input logic [31:0] afl);
        logic [7:0] emax, emin;
        int         emaxi, emini;
        ext(k, 1'b1, emax, emaxi);
        ext(k, 1'b0, emin, emini);
        cmp("max", k, amax, 32'(emax));
        cmp("min", k, amin, 32'(emin));
        cmp("maxidx", k, amaxi, emaxi);
        cmp("minidx", k, amini, emini);
        cmp("count", k, acnt, n[k]);
        cmp("outvalid", k, aov, 32'(ov[k]));
        cmp("flags", k, afl, 32'(fl[k]));
    endtask

    task automatic check_all();
        check_inst(0, s_max, s_min, s_maxi, s_mini, s_cnt, s_ov, {s_gt, s_eq, s_lt});
        check_inst(1, u_max, u_min, u_maxi, u_mini, u_cnt, u_ov, {u_gt, u_eq, u_lt});
        check_inst(2, c_max, c_min, 32'(c_maxi), 32'(c_mini), 32'(c_cnt), c_ov, {c_gt, c_eq, c_lt});
    endtask

    task automatic check_rdy();
        cmp("inready", 0, s_rdy, 32'(!Clr && !done[0]));
        cmp("inready", 1, u_rdy, 32'(!Clr && !done[1]));
        cmp("inready", 2, c_rdy, 32'(!Clr && !done[2]));
    endtask

    // Called just after a rising edge; applies inputs across the next edge and checks.
    task automatic step(input bit c, input bit v, input logic [7:0] d, input bit l);
        Clr = c; InValid = v; InData = d; InLast = l;
        #1;
        check_rdy();
        model_step(c, v, d, l);
        @(posedge Clk);
        #1;
        check_all();
    endtask

    typedef struct {
        bit         clr, vld, lst;
        logic [7:0] dat;
        logic [7:0] smax, smin;
        int         smaxi, smini, cnt;
        logic [2:0] sfl;
        bit         ov;
        logic [7:0] umax, umin;
        int         umaxi, umini;
        logic [2:0] ufl;
    } vec_t;

    function automatic vec_t mk(input bit clr, input bit vld, input logic [7:0] dat, input bit lst,
                                input logic [7:0] smax, input logic [7:0] smin, input int smaxi, input int smini,
                                input int cnt, input logic [2:0] sfl, input bit ov,
                                input logic [7:0] umax, input logic [7:0] umin, input int umaxi, input int umini,
                                input logic [2:0] ufl);
        vec_t r;
        r.clr = clr; r.vld = vld; r.dat = dat; r.lst = lst;
        r.smax = smax; r.smin = smin; r.smaxi = smaxi; r.smini = smini; r.cnt = cnt; r.sfl = sfl; r.ov = ov;
        r.umax = umax; r.umin = umin; r.umaxi = umaxi; r.umini = umini; r.ufl = ufl;
        return r;
    endfunction

    vec_t tv[$];

    initial begin
        //                clr vld dat   lst  smax   smin  smi smn cnt sfl     ov   umax   umin  umi umn ufl
        tv.push_back(mk(0, 1, 8'h05, 0, 8'h05, 8'h05, 0, 0, 1, 3'b010, 0, 8'h05, 8'h05, 0, 0, 3'b010));
        tv.push_back(mk(0, 1, 8'hFD, 0, 8'h05, 8'hFD, 0, 1, 2, 3'b001, 0, 8'hFD, 8'h05, 1, 0, 3'b100));
        tv.push_back(mk(0, 1, 8'h0C, 0, 8'h0C, 8'hFD, 2, 1, 3, 3'b100, 0, 8'hFD, 8'h05, 1, 0, 3'b001));
        tv.push_back(mk(0, 1, 8'h0C, 1, 8'h0C, 8'hFD, 2, 1, 4, 3'b010, 0, 8'hFD, 8'h05, 1, 0, 3'b001));
        tv.push_back(mk(0, 0, 8'h00, 0, 8'h0C, 8'hFD, 2, 1, 4, 3'b010, 1, 8'hFD, 8'h05, 1, 0, 3'b001));
        tv.push_back(mk(0, 1, 8'h77, 0, 8'h0C, 8'hFD, 2, 1, 4, 3'b010, 1, 8'hFD, 8'h05, 1, 0, 3'b001));
        tv.push_back(mk(1, 1, 8'h55, 0, 8'h00, 8'h00, 0, 0, 0, 3'b000, 0, 8'h00, 8'h00, 0, 0, 3'b000));
        tv.push_back(mk(0, 1, 8'h80, 1, 8'h80, 8'h80, 0, 0, 1, 3'b010, 0, 8'h80, 8'h80, 0, 0, 3'b010));
        tv.push_back(mk(0, 0, 8'h00, 0, 8'h80, 8'h80, 0, 0, 1, 3'b010, 1, 8'h80, 8'h80, 0, 0, 3'b010));
        tv.push_back(mk(0, 1, 8'h11, 0, 8'h80, 8'h80, 0, 0, 1, 3'b010, 1, 8'h80, 8'h80, 0, 0, 3'b010));
        tv.push_back(mk(1, 0, 8'h00, 0, 8'h00, 8'h00, 0, 0, 0, 3'b000, 0, 8'h00, 8'h00, 0, 0, 3'b000));
        tv.push_back(mk(0, 1, 8'h01, 0, 8'h01, 8'h01, 0, 0, 1, 3'b010, 0, 8'h01, 8'h01, 0, 0, 3'b010));
        tv.push_back(mk(0, 1, 8'h02, 0, 8'h02, 8'h01, 1, 0, 2, 3'b100, 0, 8'h02, 8'h01, 1, 0, 3'b100));
        tv.push_back(mk(0, 1, 8'h03, 0, 8'h03, 8'h01, 2, 0, 3, 3'b100, 0, 8'h03, 8'h01, 2, 0, 3'b100));
        tv.push_back(mk(1, 1, 8'h44, 0, 8'h00, 8'h00, 0, 0, 0, 3'b000, 0, 8'h00, 8'h00, 0, 0, 3'b000));
        tv.push_back(mk(0, 1, 8'h22, 0, 8'h22, 8'h22, 0, 0, 1, 3'b010, 0, 8'h22, 8'h22, 0, 0, 3'b010));

        Rst = 1'b0; Clr = 1'b0; InValid = 1'b0; InData = 8'h00; InLast = 1'b0;
        model_reset();
        #12;
        check_all();
        check_rdy();
        Rst = 1'b1;
        @(posedge Clk);
        #1;

        foreach (tv[i]) begin
            step(tv[i].clr, tv[i].vld, tv[i].dat, tv[i].lst);
            cmp("tbl_smax", i, s_max, tv[i].smax);
            cmp("tbl_smin", i, s_min, tv[i].smin);
            cmp("tbl_smaxidx", i, s_maxi, tv[i].smaxi);
            cmp("tbl_sminidx", i, s_mini, tv[i].smini);
            cmp("tbl_scount", i, s_cnt, tv[i].cnt);
            cmp("tbl_sflags", i, {s_gt, s_eq, s_lt}, tv[i].sfl);
            cmp("tbl_soutvalid", i, s_ov, tv[i].ov);
            cmp("tbl_umax", i, u_max, tv[i].umax);
            cmp("tbl_umin", i, u_min, tv[i].umin);
            cmp("tbl_umaxidx", i, u_maxi, tv[i].umaxi);
            cmp("tbl_uminidx", i, u_mini, tv[i].umini);
            cmp("tbl_uflags", i, {u_gt, u_eq, u_lt}, tv[i].ufl);
        end

        // Narrow counter saturates after three samples without InLast.
        step(1, 0, 8'h00, 0);
        step(0, 1, 8'h01, 0);
        step(0, 1, 8'h02, 0);
        step(0, 1, 8'h03, 0);
        cmp("sat_count", 2, 32'(c_cnt), 3);
        cmp("sat_inready", 2, c_rdy, 0);
        cmp("sat_outvalid_early", 2, c_ov, 0);
        step(0, 0, 8'h00, 0);
        cmp("sat_outvalid", 2, c_ov, 1);
        step(0, 1, 8'h04, 0);
        cmp("sat_ignored_count", 2, 32'(c_cnt), 3);
        cmp("sat_ignored_max", 2, c_max, 8'h03);
        cmp("nosat_count", 0, s_cnt, 4);

        // Asynchronous reset in the middle of a cycle during TRACK.
        step(1, 0, 8'h00, 0);
        step(0, 1, 8'h10, 0);
        step(0, 1, 8'h20, 0);
        @(negedge Clk);
        #2;
        Rst = 1'b0;
        InValid = 1'b0;
        #1;
        model_reset();
        cmp("arst_count", 0, s_cnt, 0);
        cmp("arst_max", 0, s_max, 0);
        cmp("arst_flags", 0, {s_gt, s_eq, s_lt}, 0);
        check_all();
        @(negedge Clk);
        Rst = 1'b1;
        @(posedge Clk);
        #1;
        check_all();
        step(0, 1, 8'h33, 0);
        cmp("arst_restart_max", 0, s_max, 8'h33);
        cmp("arst_restart_idx", 0, s_maxi, 0);
        cmp("arst_restart_count", 0, s_cnt, 1);

        // Randomized streams with frequent ties and sign crossings.
        for (int i = 0; i < 1500; i++) begin
            bit         c, v, l;
            logic [7:0] d;
            c = ($urandom_range(0, 29) == 0);
            v = ($urandom_range(0, 3) != 0);
            l = ($urandom_range(0, 24) == 0);
            if ($urandom_range(0, 1) == 1) d = 8'($urandom);
            else                           d = 8'($urandom_range(0, 7)) - 8'd4;
            step(c, v, d, l);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end

endmodule
